// File: rtl/bram_tdp_macro_if.sv
// Port bundle for the true-dual-port block RAM: enables, lane write enables,
// addresses, write data and read data for ports A and B.
interface bram_tdp_macro_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 10,
  parameter int WE_WIDTH      = (DATA_WIDTH + 7) / 8
);
  logic                     ENA;
  logic [WE_WIDTH-1:0]      WEA;
  logic [ADDRESS_WIDTH-1:0] ADDRA;
  logic [DATA_WIDTH-1:0]    DIA;
  logic [DATA_WIDTH-1:0]    DOA;

  logic                     ENB;
  logic [WE_WIDTH-1:0]      WEB;
  logic [ADDRESS_WIDTH-1:0] ADDRB;
  logic [DATA_WIDTH-1:0]    DIB;
  logic [DATA_WIDTH-1:0]    DOB;

  modport master (
    output ENA, WEA, ADDRA, DIA,
    output ENB, WEB, ADDRB, DIB,
    input  DOA, DOB
  );

  modport slave (
    input  ENA, WEA, ADDRA, DIA,
    input  ENB, WEB, ADDRB, DIB,
    output DOA, DOB
  );
endinterface

// File: rtl/bram_tdp_macro.sv
// True-dual-port block RAM primitive with per-lane byte writes, selectable
// write mode per port and an optional output pipeline register per port.
module bram_tdp_macro #(
  parameter int    DATA_WIDTH    = 16,
  parameter int    ADDRESS_WIDTH = 10,
  parameter int    WE_WIDTH      = (DATA_WIDTH + 7) / 8,
  parameter bit    DOA_REG       = 1'b0,
  parameter bit    DOB_REG       = 1'b0,
  parameter string WRITE_MODE_A  = "NO_CHANGE",
  parameter string WRITE_MODE_B  = "NO_CHANGE",
  parameter string INIT_FILE     = ""
) (
  input logic             clk,
  input logic             rst,
  bram_tdp_macro_if.slave bus
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  typedef enum logic [1:0] {
    WM_WRITE_FIRST,
    WM_READ_FIRST,
    WM_NO_CHANGE
  } write_mode_e;

  localparam write_mode_e MODE_A =
    (WRITE_MODE_A == "WRITE_FIRST") ? WM_WRITE_FIRST :
    (WRITE_MODE_A == "READ_FIRST")  ? WM_READ_FIRST  : WM_NO_CHANGE;
  localparam write_mode_e MODE_B =
    (WRITE_MODE_B == "WRITE_FIRST") ? WM_WRITE_FIRST :
    (WRITE_MODE_B == "READ_FIRST")  ? WM_READ_FIRST  : WM_NO_CHANGE;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] mask_a, mask_b;
  logic [DATA_WIDTH-1:0] old_a, old_b;
  logic [DATA_WIDTH-1:0] word_a, word_b;
  logic                  wr_a, wr_b, same_addr;
  logic [DATA_WIDTH-1:0] latch_a, latch_b;
  logic [DATA_WIDTH-1:0] latch_a_next, latch_b_next;

  // Expand lane enables to a bit mask; the top lane may be narrower than 8 bits.
  function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [WE_WIDTH-1:0] we);
    logic [DATA_WIDTH-1:0] m;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      m[b] = we[b / 8];
    end
    return m;
  endfunction

  // Power-up image: every word starts at zero.
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
    end
  end

  // On a double write to one address, shared lanes take B's data.
  always_comb begin
    mask_a    = lane_mask(bus.WEA);
    mask_b    = lane_mask(bus.WEB);
    wr_a      = bus.ENA && (bus.WEA != '0);
    wr_b      = bus.ENB && (bus.WEB != '0);
    same_addr = (bus.ADDRA == bus.ADDRB);
    old_a     = mem[bus.ADDRA];
    old_b     = mem[bus.ADDRB];
    word_a    = (old_a & ~mask_a) | (bus.DIA & mask_a);
    word_b    = (old_b & ~mask_b) | (bus.DIB & mask_b);
    if (wr_a && wr_b && same_addr) begin
      word_b = (old_b & ~(mask_a | mask_b))
             | (bus.DIA & mask_a & ~mask_b)
             | (bus.DIB & mask_b);
      word_a = word_b;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_a) begin
      mem[bus.ADDRA] <= word_a;
    end
    if (wr_b) begin
      mem[bus.ADDRB] <= word_b;
    end
  end

  always_comb begin
    latch_a_next = latch_a;
    if (!wr_a) begin
      latch_a_next = old_a;
    end else begin
      case (MODE_A)
        WM_WRITE_FIRST: latch_a_next = word_a;
        WM_READ_FIRST:  latch_a_next = old_a;
        default:        latch_a_next = latch_a;
      endcase
    end
  end

  always_comb begin
    latch_b_next = latch_b;
    if (!wr_b) begin
      latch_b_next = old_b;
    end else begin
      case (MODE_B)
        WM_WRITE_FIRST: latch_b_next = word_b;
        WM_READ_FIRST:  latch_b_next = old_b;
        default:        latch_b_next = latch_b;
      endcase
    end
  end

  // A capture attempted while rst is high is dropped; the latch stays zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch_a <= '0;
    end else if (bus.ENA) begin
      latch_a <= latch_a_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch_b <= '0;
    end else if (bus.ENB) begin
      latch_b <= latch_b_next;
    end
  end

  if (DOA_REG) begin : g_pipe_a
    logic [DATA_WIDTH-1:0] pipe_a;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pipe_a <= '0;
      end else if (bus.ENA) begin
        pipe_a <= latch_a;
      end
    end
    assign bus.DOA = pipe_a;
  end else begin : g_direct_a
    assign bus.DOA = latch_a;
  end

  if (DOB_REG) begin : g_pipe_b
    logic [DATA_WIDTH-1:0] pipe_b;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pipe_b <= '0;
      end else if (bus.ENB) begin
        pipe_b <= latch_b;
      end
    end
    assign bus.DOB = pipe_b;
  end else begin : g_direct_b
    assign bus.DOB = latch_b;
  end

endmodule

// File: tb/tb_bram_tdp_macro.sv
// Scoreboard bench for bram_tdp_macro: three instances cover NO_CHANGE ports,
// WRITE_FIRST/READ_FIRST ports, and a pipelined port B.
module tb_bram_tdp_macro;
  localparam int DW = 16;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  bram_tdp_macro_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus0 ();
  bram_tdp_macro_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus1 ();
  bram_tdp_macro_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus2 ();

  bram_tdp_macro #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  bram_tdp_macro #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW),
    .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("READ_FIRST")
  ) dut_modes (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  bram_tdp_macro #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DOB_REG(1'b1)) dut_pipe (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] expv;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus0.ENA = 0; bus0.WEA = '0; bus0.ADDRA = '0; bus0.DIA = '0;
    bus0.ENB = 0; bus0.WEB = '0; bus0.ADDRB = '0; bus0.DIB = '0;
    bus1.ENA = 0; bus1.WEA = '0; bus1.ADDRA = '0; bus1.DIA = '0;
    bus1.ENB = 0; bus1.WEB = '0; bus1.ADDRB = '0; bus1.DIB = '0;
    bus2.ENA = 0; bus2.WEA = '0; bus2.ADDRA = '0; bus2.DIA = '0;
    bus2.ENB = 0; bus2.WEB = '0; bus2.ADDRB = '0; bus2.DIB = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    tick();
    tick();
    checks++;
    if (bus0.DOA !== 16'h0000) begin errors++; $display("[TB] FAIL reset_doa: got %h want %h", bus0.DOA, 16'h0000); end
    checks++;
    if (bus0.DOB !== 16'h0000) begin errors++; $display("[TB] FAIL reset_dob: got %h want %h", bus0.DOB, 16'h0000); end
    checks++;
    if (bus2.DOB !== 16'h0000) begin errors++; $display("[TB] FAIL reset_pipe_dob: got %h want %h", bus2.DOB, 16'h0000); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill_readback();
    bus0.ENA = 1; bus0.WEA = 2'b11; bus0.ADDRA = '0; bus0.DIA = 16'hBEEF;
    tick();
    bus0.WEA = 2'b00;
    exp_q.push_back(16'hBEEF);
    tick();
    expv = exp_q.pop_front();
    checks++;
    if (bus0.DOA !== expv) begin errors++; $display("[TB] FAIL fill_prime_doa: got %h want %h", bus0.DOA, expv); end
    for (int k = 0; k < 1024; k++) begin
      bus0.ENA = 1; bus0.WEA = 2'b11; bus0.ADDRA = AW'(k); bus0.DIA = DW'(k);
      exp_q.push_back(16'hBEEF);
      tick();
      expv = exp_q.pop_front();
      checks++;
      if (bus0.DOA !== expv) begin errors++; $display("[TB] FAIL fill_doa_hold k=%0d: got %h want %h", k, bus0.DOA, expv); end
    end
    bus0.ENA = 0; bus0.WEA = '0;
    for (int k = 0; k < 1024; k++) begin
      bus0.ENB = 1; bus0.WEB = '0; bus0.ADDRB = AW'(k);
      exp_q.push_back(DW'(k));
      tick();
      expv = exp_q.pop_front();
      checks++;
      if (bus0.DOB !== expv) begin errors++; $display("[TB] FAIL readback k=%0d: got %h want %h", k, bus0.DOB, expv); end
    end
    bus0.ENB = 0;
  endtask

  task automatic test_byte_lanes();
    bus0.ENA = 1; bus0.WEA = 2'b11; bus0.ADDRA = 10'd5; bus0.DIA = 16'hAAAA;
    tick();
    bus0.WEA = 2'b01; bus0.DIA = 16'h1234;
    tick();
    bus0.ENA = 0; bus0.WEA = '0;
    bus0.ENB = 1; bus0.WEB = '0; bus0.ADDRB = 10'd5;
    exp_q.push_back(16'hAA34);
    tick();
    expv = exp_q.pop_front();
    checks++;
    if (bus0.DOB !== expv) begin errors++; $display("[TB] FAIL lane_low: got %h want %h", bus0.DOB, expv); end
    bus0.ENB = 0;
    bus0.ENA = 1; bus0.WEA = 2'b10; bus0.DIA = 16'h5678;
    tick();
    bus0.ENA = 0; bus0.WEA = '0;
    bus0.ENB = 1;
    exp_q.push_back(16'h5634);
    tick();
    expv = exp_q.pop_front();
    checks++;
    if (bus0.DOB !== expv) begin errors++; $display("[TB] FAIL lane_high: got %h want %h", bus0.DOB, expv); end
    bus0.ENB = 0;
  endtask

  task automatic test_write_modes();
    // Port A of dut_modes is WRITE_FIRST
    bus1.ENA = 1; bus1.WEA = 2'b11; bus1.ADDRA = 10'd7; bus1.DIA = 16'h0011;
    exp_q.push_back(16'h0011);
    tick();
    expv = exp_q.pop_front();
    checks++;
    if (bus1.DOA !== expv) begin errors++; $display("[TB] FAIL wf_first: got %h want %h", bus1.DOA, expv); end
    bus1.DIA = 16'h00FF;
    exp_q.push_back(16'h00FF);
    tick();
    expv = exp_q.pop_front();
    checks++;
    if (bus1.DOA !== expv) begin errors++; $display("[TB] FAIL wf_new: got %h want %h", bus1.DOA, expv); end
    bus1.WEA = 2'b10; bus1.DIA = 16'hAB00;
    exp_q.push_back(16'hABFF);
    tick();
    expv = exp_q.pop_front();
    checks++;
    if (bus1.DOA !== expv) begin errors++; $display("[TB] FAIL wf_merged: got %h want %h", bus1.DOA, expv); end
    bus1.ENA = 0; bus1.WEA = '0;
    // Port B of dut_modes is READ_FIRST
    bus1.ENB = 1; bus1.WEB = 2'b11; bus1.ADDRB = 10'd7; bus1.DIB = 16'h0011;
    exp_q.push_back(16'hABFF);
    tick();
    expv = exp_q.pop_front();
    checks++;
    if (bus1.DOB !== expv) begin errors++; $display("[TB] FAIL rf_old1: got %h want %h", bus1.DOB, expv); end
    bus1.DIB = 16'h00FF;
    exp_q.push_back(16'h0011);
    tick();
    expv = exp_q.pop_front();
    checks++;
    if (bus1.DOB !== expv) begin errors++; $display("[TB] FAIL rf_old2: got %h want %h", bus1.DOB, expv); end
    bus1.ENB = 0; bus1.WEB = '0;
    // Port A of dut is NO_CHANGE
    bus0.ENA = 1; bus0.WEA = 2'b11; bus0.ADDRA = 10'd7; bus0.DIA = 16'h0011;
    tick();
    bus0.WEA = '0;
    exp_q.push_back(16'h0011);
    tick();
    expv = exp_q.pop_front();
    checks++;
    if (bus0.DOA !== expv) begin errors++; $display("[TB] FAIL nc_read: got %h want %h", bus0.DOA, expv); end
    bus0.WEA = 2'b11; bus0.DIA = 16'h00FF;
    exp_q.push_back(16'h0011);
    tick();
    expv = exp_q.pop_front();
    checks++;
    if (bus0.DOA !== expv) begin errors++; $display("[TB] FAIL nc_hold: got %h want %h", bus0.DOA, expv); end
    bus0.ENA = 0; bus0.WEA = '0;
    bus0.ENB = 1; bus0.WEB = '0; bus0.ADDRB = 10'd7;
    exp_q.push_back(16'h00FF);
    tick();
    expv = exp_q.pop_front();
    checks++;
    if (bus0.DOB !== expv) begin errors++; $display("[TB] FAIL nc_stored: got %h want %h", bus0.DOB, expv); end
    bus0.ENB = 0;
  endtask

  task automatic test_collision();
    bus0.ENA = 1; bus0.WEA = 2'b11; bus0.ADDRA = 10'd3; bus0.DIA = 16'h1111;
    bus0.ENB = 1; bus0.WEB = 2'b11; bus0.ADDRB = 10'd3; bus0.DIB = 16'h2222;
    tick();
    bus0.ENB = 0; bus0.WEB = '0; bus0.WEA = '0;
    exp_q.push_back(16'h2222);
    tick();
    expv = exp_q.pop_front();
    checks++;
    if (bus0.DOA !== expv) begin errors++; $display("[TB] FAIL coll_full: got %h want %h", bus0.DOA, expv); end
    bus0.WEA = 2'b11; bus0.DIA = 16'hAAAA;
    bus0.ENB = 1; bus0.WEB = 2'b01; bus0.DIB = 16'hBBBB;
    tick();
    bus0.ENB = 0; bus0.WEB = '0; bus0.WEA = '0;
    exp_q.push_back(16'hAABB);
    tick();
    expv = exp_q.pop_front();
    checks++;
    if (bus0.DOA !== expv) begin errors++; $display("[TB] FAIL coll_lanes: got %h want %h", bus0.DOA, expv); end
    bus0.WEA = 2'b11; bus0.ADDRA = 10'd4; bus0.DIA = 16'h0000;
    tick();
    bus0.DIA = 16'h5555;
    bus0.ENB = 1; bus0.WEB = '0; bus0.ADDRB = 10'd4;
    exp_q.push_back(16'h0000);
    tick();
    expv = exp_q.pop_front();
    checks++;
    if (bus0.DOB !== expv) begin errors++; $display("[TB] FAIL coll_read_old: got %h want %h", bus0.DOB, expv); end
    bus0.ENA = 0; bus0.WEA = '0;
    exp_q.push_back(16'h5555);
    tick();
    expv = exp_q.pop_front();
    checks++;
    if (bus0.DOB !== expv) begin errors++; $display("[TB] FAIL coll_after: got %h want %h", bus0.DOB, expv); end
    bus0.ENB = 0;
  endtask

  task automatic test_reset_enable();
    bus0.ENA = 1; bus0.WEA = 2'b11; bus0.ADDRA = 10'd10; bus0.DIA = 16'h0042;
    tick();
    bus0.ENA = 0; bus0.WEA = '0;
    bus0.ENB = 1; bus0.WEB = '0; bus0.ADDRB = 10'd10;
    exp_q.push_back(16'h0042);
    tick();
    expv = exp_q.pop_front();
    checks++;
    if (bus0.DOB !== expv) begin errors++; $display("[TB] FAIL rst_pre: got %h want %h", bus0.DOB, expv); end
    bus0.ENB = 0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus0.DOB !== 16'h0000) begin errors++; $display("[TB] FAIL rst_async: got %h want %h", bus0.DOB, 16'h0000); end
    bus0.ENA = 1; bus0.WEA = 2'b11; bus0.ADDRA = 10'd11; bus0.DIA = 16'h7777;
    bus0.ENB = 1; bus0.ADDRB = 10'd10;
    tick();
    checks++;
    if (bus0.DOB !== 16'h0000) begin errors++; $display("[TB] FAIL rst_read_drop: got %h want %h", bus0.DOB, 16'h0000); end
    rst = 1'b0;
    bus0.ENA = 0; bus0.WEA = '0; bus0.ENB = 0;
    tick();
    checks++;
    if (bus0.DOB !== 16'h0000) begin errors++; $display("[TB] FAIL rst_en_low: got %h want %h", bus0.DOB, 16'h0000); end
    bus0.ENB = 1; bus0.ADDRB = 10'd10;
    exp_q.push_back(16'h0042);
    tick();
    expv = exp_q.pop_front();
    checks++;
    if (bus0.DOB !== expv) begin errors++; $display("[TB] FAIL rst_retained: got %h want %h", bus0.DOB, expv); end
    bus0.ADDRB = 10'd11;
    exp_q.push_back(16'h7777);
    tick();
    expv = exp_q.pop_front();
    checks++;
    if (bus0.DOB !== expv) begin errors++; $display("[TB] FAIL rst_write_kept: got %h want %h", bus0.DOB, expv); end
    bus0.ENB = 0;
  endtask

  task automatic test_pipeline();
    bus2.ENA = 1; bus2.WEA = 2'b11; bus2.ADDRA = 10'd9; bus2.DIA = 16'h0909;
    tick();
    bus2.ENA = 0; bus2.WEA = '0;
    bus2.ENB = 1; bus2.WEB = '0; bus2.ADDRB = 10'd9;
    tick();
    checks++;
    if (bus2.DOB !== 16'h0000) begin errors++; $display("[TB] FAIL pipe_early: got %h want %h", bus2.DOB, 16'h0000); end
    exp_q.push_back(16'h0909);
    tick();
    expv = exp_q.pop_front();
    checks++;
    if (bus2.DOB !== expv) begin errors++; $display("[TB] FAIL pipe_data: got %h want %h", bus2.DOB, expv); end
    bus2.ENB = 0; bus2.ADDRB = 10'd0;
    tick();
    checks++;
    if (bus2.DOB !== 16'h0909) begin errors++; $display("[TB] FAIL pipe_hold: got %h want %h", bus2.DOB, 16'h0909); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      bus2.ENA = 1; bus2.WEA = 2'b11; bus2.ADDRA = AW'(20 + i); bus2.DIA = DW'(16'h2000 + i);
      tick();
    end
    bus2.ENA = 0; bus2.WEA = '0;
    for (int cyc = 0; cyc < 9; cyc++) begin
      bus2.ENB = 1; bus2.WEB = '0;
      if (cyc < 8) begin
        bus2.ADDRB = AW'(20 + cyc);
        exp_q.push_back(DW'(16'h2000 + cyc));
      end else begin
        bus2.ADDRB = '0;
      end
      tick();
      if (cyc >= 1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("[TB] FAIL b2b_queue_empty cyc=%0d: got %0d entries want 1", cyc, exp_q.size());
        end else begin
          expv = exp_q.pop_front();
          if (bus2.DOB !== expv) begin errors++; $display("[TB] FAIL b2b cyc=%0d: got %h want %h", cyc, bus2.DOB, expv); end
        end
      end
    end
    bus2.ENB = 0;
  endtask

  initial begin
    test_reset();
    test_fill_readback();
    test_byte_lanes();
    test_write_modes();
    test_collision();
    test_reset_enable();
    test_pipeline();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
